// File: rtl/pp_seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// pp_seq_multiplier_if
// Handshake bundle for the sequential partial-product multiplier.
//   in_valid / in_ready   : operand-side valid/ready handshake
//   in1 [W1]              : multiplicand
//   in2 [W2]              : multiplier
//   in_signed             : 1 = two's-complement operands, 0 = unsigned
//   out_valid / out_ready : result-side valid/ready handshake
//   product [W1+W2]       : full-width result
// master = operand producer / result consumer, slave = the multiplier.
// ---------------------------------------------------------------------------
interface pp_seq_multiplier_if #(
    parameter int W1 = 64,
    parameter int W2 = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [W1-1:0]      in1;
    logic [W2-1:0]      in2;
    logic               in_signed;
    logic               out_valid;
    logic               out_ready;
    logic [W1+W2-1:0]   product;

    modport master (
        output in_valid, in1, in2, in_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, in1, in2, in_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/pp_seq_multiplier.sv
// ---------------------------------------------------------------------------
// pp_seq_multiplier
// Sequential multiplier: each RUN cycle generates K AND-based partial-product
// rows and adds them into a (W1+W2)-bit accumulator. Signed operands are
// converted to magnitudes at capture; the sign is re-applied when the result
// is registered. Latency from acceptance to out_valid is W2/K + 1 cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (priority over all handshakes)
//   bus   : slave side of pp_seq_multiplier_if (operands, handshakes, product)
// ---------------------------------------------------------------------------
module pp_seq_multiplier #(
    parameter int W1 = 64,
    parameter int W2 = 32,
    parameter int K  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pp_seq_multiplier_if.slave    bus
);
    localparam int PW = W1 + W2;
    localparam int N  = W2 / K;
    // Counter must reach N: 0..N-1 are accumulation groups, N is the
    // finalisation cycle that registers the signed product.
    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_mag1_sh;    // |in1| pre-shifted to the current group
    logic [W2-1:0]    r_mag2;       // |in2| shifted right so bits [K-1:0] are the current group
    logic             r_neg;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_product;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [PW-1:0]    w_grp_sum;
    logic             w_accept;
    logic             w_release;
    logic             w_run_last;

    // Magnitude of a possibly-signed multiplicand; most-negative maps to 2^(W1-1).
    function automatic logic [W1-1:0] abs1(input logic [W1-1:0] v, input logic sgn);
        return (sgn && v[W1-1]) ? ('0 - v) : v;
    endfunction

    // Magnitude of a possibly-signed multiplier.
    function automatic logic [W2-1:0] abs2(input logic [W2-1:0] v, input logic sgn);
        return (sgn && v[W2-1]) ? ('0 - v) : v;
    endfunction

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_release  = r_out_valid & bus.out_ready;
    assign w_run_last = (r_cnt == CW'(N));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

    // Sum of the K partial-product rows for the current group.
    always_comb begin
        w_grp_sum = '0;
        for (int i = 0; i < K; i++) begin
            w_grp_sum = w_grp_sum + ((r_mag1_sh & {PW{r_mag2[i]}}) << i);
        end
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_run_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                if (w_release) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus registered handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == S_IDLE);
            r_out_valid <= (w_next_state == S_DONE);
        end
    end

    // Datapath: operand capture, group accumulation, signed finalisation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag1_sh <= '0;
            r_mag2    <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag1_sh <= {{W2{1'b0}}, abs1(bus.in1, bus.in_signed)};
                        r_mag2    <= abs2(bus.in2, bus.in_signed);
                        r_neg     <= bus.in_signed & (bus.in1[W1-1] ^ bus.in2[W2-1]);
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt     <= r_cnt;
                    end
                end
                S_RUN: begin
                    if (!w_run_last) begin
                        r_acc     <= r_acc + w_grp_sum;
                        r_mag1_sh <= r_mag1_sh << K;
                        r_mag2    <= r_mag2 >> K;
                        r_cnt     <= r_cnt + CW'(1'b1);
                    end else begin
                        r_product <= r_neg ? ('0 - r_acc) : r_acc;
                    end
                end
                S_DONE: begin
                    r_product <= r_product;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end
endmodule
